iexecute: RTL and testbench

//  Third pipeline stage (EX): consumes ID/EX-latched outputs of the decode stage, derives the ALU

---
 rtl/iexecute.sv | 122 ++++++++++++
 tb/tb_iexecute.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/iexecute.sv
// EX pipeline stage: ALU control, ALU, branch target, dest select.
// Results are latched into the EX/MEM register with stall/flush.
module iexecute #(
  parameter int BR_SHIFT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_stall,
  input  logic        ex_flush,
  input  logic [1:0]  wb_ctl,
  input  logic [2:0]  m_ctl,
  input  logic        regdst,
  input  logic        alusrc,
  input  logic [1:0]  aluop,
  input  logic [31:0] npc,
  input  logic [31:0] rdata1,
  input  logic [31:0] rdata2,
  input  logic [31:0] s_extend,
  input  logic [4:0]  instr_2016,
  input  logic [4:0]  instr_1511,
  output logic [1:0]  EX_MEM_wb_ctlout,
  output logic        EX_MEM_branch,
  output logic        EX_MEM_memread,
  output logic        EX_MEM_memwrite,
  output logic [31:0] EX_MEM_add_result,
  output logic        EX_MEM_zero,
  output logic [31:0] EX_MEM_alu_result,
  output logic [31:0] EX_MEM_rdata2out,
  output logic [4:0]  EX_MEM_dest_reg
);

  typedef enum logic [2:0] {
    OP_NOP,
    OP_ADD,
    OP_SUB,
    OP_AND,
    OP_OR,
    OP_SLT
  } alu_op_e;

  alu_op_e     alu_op;
  logic [5:0]  funct;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] alu_res;
  logic [31:0] br_target;
  logic [4:0]  dest;

  assign funct = s_extend[5:0];
  assign op_a  = rdata1;
  assign op_b  = alusrc ? s_extend : rdata2;
  assign dest  = regdst ? instr_1511 : instr_2016;

  assign br_target = npc + (s_extend << BR_SHIFT);

  always_comb begin
    alu_op = OP_NOP;
    unique case (aluop)
      2'b00: alu_op = OP_ADD;
      2'b01: alu_op = OP_SUB;
      2'b10: begin
        case (funct)
          6'b100000: alu_op = OP_ADD;
          6'b100010: alu_op = OP_SUB;
          6'b100100: alu_op = OP_AND;
          6'b100101: alu_op = OP_OR;
          6'b101010: alu_op = OP_SLT;
          default:   alu_op = OP_NOP;
        endcase
      end
      default: alu_op = OP_NOP;
    endcase
  end

  always_comb begin
    alu_res = '0;
    unique case (alu_op)
      OP_ADD: alu_res = op_a + op_b;
      OP_SUB: alu_res = op_a - op_b;
      OP_AND: alu_res = op_a & op_b;
      OP_OR:  alu_res = op_a | op_b;
      OP_SLT: alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
      default: alu_res = '0;
    endcase
  end

  // Flush beats stall so a bubble can replace a held entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      EX_MEM_wb_ctlout  <= '0;
      EX_MEM_branch     <= 1'b0;
      EX_MEM_memread    <= 1'b0;
      EX_MEM_memwrite   <= 1'b0;
      EX_MEM_add_result <= '0;
      EX_MEM_zero       <= 1'b0;
      EX_MEM_alu_result <= '0;
      EX_MEM_rdata2out  <= '0;
      EX_MEM_dest_reg   <= '0;
    end else if (ex_flush) begin
      EX_MEM_wb_ctlout  <= '0;
      EX_MEM_branch     <= 1'b0;
      EX_MEM_memread    <= 1'b0;
      EX_MEM_memwrite   <= 1'b0;
      EX_MEM_add_result <= '0;
      EX_MEM_zero       <= 1'b0;
      EX_MEM_alu_result <= '0;
      EX_MEM_rdata2out  <= '0;
      EX_MEM_dest_reg   <= '0;
    end else if (!ex_stall) begin
      EX_MEM_wb_ctlout  <= wb_ctl;
      EX_MEM_branch     <= m_ctl[2];
      EX_MEM_memread    <= m_ctl[1];
      EX_MEM_memwrite   <= m_ctl[0];
      EX_MEM_add_result <= br_target;
      EX_MEM_zero       <= (alu_res == 32'd0);
      EX_MEM_alu_result <= alu_res;
      EX_MEM_rdata2out  <= rdata2;
      EX_MEM_dest_reg   <= dest;
    end
  end

endmodule

// File: tb/tb_iexecute.sv
// Randomized and directed bench for iexecute.
// Expected EX/MEM contents come from an arithmetic reference model.
module tb_iexecute;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_stall = 1'b0;
  logic        ex_flush = 1'b0;
  logic [1:0]  wb_ctl = '0;
  logic [2:0]  m_ctl = '0;
  logic        regdst = 1'b0;
  logic        alusrc = 1'b0;
  logic [1:0]  aluop = '0;
  logic [31:0] npc = '0;
  logic [31:0] rdata1 = '0;
  logic [31:0] rdata2 = '0;
  logic [31:0] s_extend = '0;
  logic [4:0]  instr_2016 = '0;
  logic [4:0]  instr_1511 = '0;
  logic [1:0]  wb_o;
  logic        br_o, mr_o, mw_o, z_o;
  logic [31:0] add_o, alu_o, rd2_o;
  logic [4:0]  dst_o;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [1:0]  wb;
    logic        br;
    logic        mr;
    logic        mw;
    logic [31:0] add;
    logic        z;
    logic [31:0] alu;
    logic [31:0] rd2;
    logic [4:0]  dst;
  } exmem_t;

  exmem_t exp_q = '0;

  iexecute #(.BR_SHIFT(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_stall(ex_stall), .ex_flush(ex_flush),
    .wb_ctl(wb_ctl), .m_ctl(m_ctl),
    .regdst(regdst), .alusrc(alusrc),
    .aluop(aluop), .npc(npc),
    .rdata1(rdata1), .rdata2(rdata2),
    .s_extend(s_extend),
    .instr_2016(instr_2016),
    .instr_1511(instr_1511),
    .EX_MEM_wb_ctlout(wb_o),
    .EX_MEM_branch(br_o),
    .EX_MEM_memread(mr_o),
    .EX_MEM_memwrite(mw_o),
    .EX_MEM_add_result(add_o),
    .EX_MEM_zero(z_o),
    .EX_MEM_alu_result(alu_o),
    .EX_MEM_rdata2out(rd2_o),
    .EX_MEM_dest_reg(dst_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] ref_alu(
    input logic [1:0] op, input logic [5:0] f,
    input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    if (op == 2'd0) return a + b;
    if (op == 2'd1) return a - b;
    if (op == 2'd3) return 32'd0;
    case (f)
      6'd32: return a + b;
      6'd34: return a - b;
      6'd36: return a & b;
      6'd37: return a | b;
      6'd42: return (sa < sb) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic exmem_t ref_load();
    exmem_t e;
    logic [31:0] b;
    b = alusrc ? s_extend : rdata2;
    e.wb  = wb_ctl;
    e.br  = m_ctl[2];
    e.mr  = m_ctl[1];
    e.mw  = m_ctl[0];
    e.add = npc + s_extend * 32'd4;
    e.alu = ref_alu(aluop, s_extend[5:0], rdata1, b);
    e.z   = (e.alu == 32'd0);
    e.rd2 = rdata2;
    e.dst = regdst ? instr_1511 : instr_2016;
    return e;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".wb"},  {30'd0, wb_o}, {30'd0, exp_q.wb});
    chk({tag, ".br"},  {31'd0, br_o}, {31'd0, exp_q.br});
    chk({tag, ".mr"},  {31'd0, mr_o}, {31'd0, exp_q.mr});
    chk({tag, ".mw"},  {31'd0, mw_o}, {31'd0, exp_q.mw});
    chk({tag, ".add"}, add_o, exp_q.add);
    chk({tag, ".z"},   {31'd0, z_o}, {31'd0, exp_q.z});
    chk({tag, ".alu"}, alu_o, exp_q.alu);
    chk({tag, ".rd2"}, rd2_o, exp_q.rd2);
    chk({tag, ".dst"}, {27'd0, dst_o}, {27'd0, exp_q.dst});
  endtask

  task automatic step(input logic st, input logic fl,
                      input string tag);
    exmem_t nxt;
    ex_stall = st;
    ex_flush = fl;
    if (fl) nxt = '0;
    else if (st) nxt = exp_q;
    else nxt = ref_load();
    @(posedge clk);
    #1;
    exp_q = nxt;
    check_all(tag);
  endtask

  task automatic drive(
    input logic [1:0] wb, input logic [2:0] m,
    input logic rdst, input logic asrc,
    input logic [1:0] op, input logic [31:0] pc,
    input logic [31:0] r1, input logic [31:0] r2,
    input logic [31:0] se,
    input logic [4:0] rt, input logic [4:0] rd);
    wb_ctl = wb; m_ctl = m; regdst = rdst;
    alusrc = asrc; aluop = op; npc = pc;
    rdata1 = r1; rdata2 = r2; s_extend = se;
    instr_2016 = rt; instr_1511 = rd;
  endtask

  logic [5:0] functs [7] = '{6'd32, 6'd34, 6'd36,
                             6'd37, 6'd42, 6'd7, 6'd0};

  initial begin
    #2;
    exp_q = '0;
    check_all("rst0");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // R-type ADD
    drive(2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'd0,
          32'd7, 32'd5, 32'h20, 5'd1, 5'd3);
    step(1'b0, 1'b0, "add");
    chk("add.val", alu_o, 32'd12);

    // Async reset mid-cycle
    #2;
    rst_n = 1'b0;
    #1;
    exp_q = '0;
    check_all("arst");
    #1;
    rst_n = 1'b1;

    // BEQ taken, forward and backward offsets
    drive(2'b00, 3'b100, 1'b0, 1'b0, 2'b01, 32'd100,
          32'd9, 32'd9, 32'd4, 5'd0, 5'd0);
    step(1'b0, 1'b0, "beq");
    chk("beq.tgt", add_o, 32'd116);
    s_extend = 32'hFFFF_FFFF;
    step(1'b0, 1'b0, "beqb");
    chk("beqb.tgt", add_o, 32'd96);

    // SLT signed
    drive(2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'd0,
          32'hFFFF_FFFF, 32'd1, 32'h2A, 5'd0, 5'd4);
    step(1'b0, 1'b0, "slt");
    chk("slt.val", alu_o, 32'd1);

    // LW, then stall, flush+stall, release
    drive(2'b11, 3'b010, 1'b0, 1'b1, 2'b00, 32'd0,
          32'd40, 32'd77, 32'd8, 5'd9, 5'd2);
    step(1'b0, 1'b0, "lw");
    chk("lw.val", alu_o, 32'd48);
    drive(2'b10, 3'b001, 1'b1, 1'b0, 2'b10, 32'd4,
          32'd1, 32'd2, 32'h22, 5'd5, 5'd6);
    step(1'b1, 1'b0, "stall");
    step(1'b1, 1'b1, "flush");
    step(1'b0, 1'b0, "rel");

    // Illegal funct, aluop 11, overflow wrap
    drive(2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'd0,
          32'd3, 32'd4, 32'h07, 5'd0, 5'd1);
    step(1'b0, 1'b0, "ill");
    chk("ill.z", {31'd0, z_o}, 32'd1);
    aluop = 2'b11;
    step(1'b0, 1'b0, "op11");
    drive(2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'd0,
          32'h7FFF_FFFF, 32'd1, 32'h20, 5'd0, 5'd1);
    step(1'b0, 1'b0, "ovf");
    chk("ovf.val", alu_o, 32'h8000_0000);

    for (int i = 0; i < 300; i++) begin
      logic [31:0] se;
      logic [1:0]  op;
      op = 2'($urandom_range(0, 3));
      se = {{16{1'b0}}, 16'($urandom)};
      if (se[15]) se[31:16] = 16'hFFFF;
      if (op == 2'b10) se[5:0] = functs[$urandom_range(0, 6)];
      drive(2'($urandom), 3'($urandom),
            1'($urandom), 1'($urandom), op,
            $urandom, $urandom,
            ($urandom_range(0, 3) == 0) ? rdata1 : $urandom,
            se, 5'($urandom), 5'($urandom));
      step(($urandom_range(0, 5) == 0),
           ($urandom_range(0, 9) == 0), "rnd");
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
